// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous fetch FIFO with a registered head, synchronous flush and occupancy count.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned  W         = 64,
    parameter int unsigned  DEPTH     = 4,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    // Flush wins over both push and pop; a push into a full queue is only taken alongside a pop.
    always_comb begin
        do_pop  = pop_i && !flush_i && (count_q != '0);
        do_push = push_i && !flush_i && ((count_q != CW'(DEPTH)) || do_pop);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited in-order requests, response queue, redirect flush.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned        XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]    RESET_PC = riscv_pkg::RESET_PC,
    parameter int unsigned        FQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall_d,
    output logic            if_valid,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pcplus4
);

    localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned EW = ILEN + XLEN;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   fq_count;
    logic [EW-1:0]   fq_head;
    logic [XLEN-1:0] redir_tgt;
    logic            req_fire;
    logic            rsp_eff;
    logic            push;
    logic            pop;

    // Decode handshake, response qualification and credit-based issue.
    always_comb begin
        redir_tgt      = redirect_pc & ~XLEN'(3);
        rsp_eff        = imem_rsp_valid && (out_q != '0);
        imem_req_valid = rst && !redirect_valid
                         && ((SW'(fq_count) + SW'(out_q)) < SW'(FQ_DEPTH));
        req_fire       = imem_req_valid && imem_req_ready;
        push           = rsp_eff && (drop_q == '0) && !redirect_valid;
        if_valid       = (fq_count != '0);
        pop            = if_valid && !stall_d && !redirect_valid;
    end

    // Next-state for PCs and in-flight bookkeeping; a redirect overrides everything.
    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        drop_d   = drop_q;
        out_d    = out_q + CW'(req_fire) - CW'(rsp_eff);
        if (redirect_valid) begin
            pc_d     = redir_tgt;
            rsp_pc_d = redir_tgt;
            drop_d   = out_q - CW'(rsp_eff);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + XLEN'(4);
            end
            if (rsp_eff && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    // PC and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
        end
    end

    fetch_queue #(
        .W        (EW),
        .DEPTH    (FQ_DEPTH),
        .RESET_VAL({ILEN'(0), RESET_PC})
    ) u_fq (
        .clk    (clk),
        .rst    (rst),
        .flush_i(redirect_valid),
        .push_i (push),
        .data_i ({imem_rsp_data, rsp_pc_q}),
        .pop_i  (pop),
        .head_o (fq_head),
        .count_o(fq_count)
    );

    assign imem_req_addr = pc_q;
    assign if_instr      = fq_head[EW-1:XLEN];
    assign if_pc         = fq_head[XLEN-1:0];
    assign if_pcplus4    = fq_head[XLEN-1:0] + XLEN'(4);

    // A response with nothing in flight breaks the memory protocol.
    rsp_without_req: assert property (@(posedge clk) disable iff (!rst)
        !(imem_rsp_valid && (out_q == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with an in-order variable-latency memory model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_d;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pcplus4;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall_d       (stall_d),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pcplus4    (if_pcplus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        int          lat;
        int          redir_at;
        logic [31:0] redir_pc;
        int          cycles;
        int          exp_pre;
        logic [31:0] exp_first;
    } vec_t;

    mreq_t       mem_q[$];
    vec_t        vecs[4];
    int          n_chk;
    int          n_fail;
    int          cyc;
    int          lat;
    int          consumed;
    int          issued;
    int          pre_cnt;
    bit          got_first;
    logic [31:0] first_pc;
    logic [31:0] exp_req_addr;
    logic [31:0] exp_dec_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample at negedge, update models, drive memory response after posedge.
    task automatic step();
        @(negedge clk);
        if (redirect_valid) begin
            chk("req_valid_during_redirect", 32'(imem_req_valid), 32'd0);
        end
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_req_addr);
            mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
            exp_req_addr = exp_req_addr + 32'd4;
            issued++;
        end
        if (if_valid && !stall_d && !redirect_valid) begin
            chk("if_pc", if_pc, exp_dec_pc);
            chk("if_instr", if_instr, mem_word(exp_dec_pc));
            chk("if_pcplus4", if_pcplus4, exp_dec_pc + 32'd4);
            if (!got_first) begin
                first_pc  = if_pc;
                got_first = 1'b1;
            end
            exp_dec_pc = exp_dec_pc + 32'd4;
            consumed++;
        end
        if (redirect_valid) begin
            exp_req_addr = redirect_pc & 32'hFFFF_FFFC;
            exp_dec_pc   = redirect_pc & 32'hFFFF_FFFC;
            got_first    = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'd0;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        stall_d        = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        imem_req_ready = 1'b1;
        mem_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst          = 1'b1;
        cyc          = 0;
        exp_req_addr = 32'd0;
        exp_dec_pc   = 32'd0;
        consumed     = 0;
        issued       = 0;
        got_first    = 1'b0;
        first_pc     = 32'hDEAD_BEEF;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        lat = 1;

        vecs[0] = '{lat: 1, redir_at: -1, redir_pc: 32'h0,         cycles: 20, exp_pre: 18, exp_first: 32'h0};
        vecs[1] = '{lat: 3, redir_at: 3,  redir_pc: 32'h40,        cycles: 25, exp_pre: 0,  exp_first: 32'h40};
        vecs[2] = '{lat: 1, redir_at: 6,  redir_pc: 32'h43,        cycles: 20, exp_pre: 4,  exp_first: 32'h40};
        vecs[3] = '{lat: 2, redir_at: 4,  redir_pc: 32'hFFFF_FFF8, cycles: 20, exp_pre: 1,  exp_first: 32'hFFFF_FFF8};

        // Reset state
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        stall_d        = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        imem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_pcplus4", if_pcplus4, 32'h4);

        // Table-driven streaming and redirect scenarios
        foreach (vecs[v]) begin
            do_reset();
            lat     = vecs[v].lat;
            pre_cnt = -1;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                redirect_valid = (c == vecs[v].redir_at);
                redirect_pc    = vecs[v].redir_pc;
                if (redirect_valid) pre_cnt = consumed;
                step();
                redirect_valid = 1'b0;
            end
            if (pre_cnt < 0) pre_cnt = consumed;
            chk($sformatf("vec%0d_consumed_before_redirect", v), 32'(pre_cnt), 32'(vecs[v].exp_pre));
            chk($sformatf("vec%0d_first_pc", v), first_pc, vecs[v].exp_first);
        end

        // Decode stall: credits fill to FQ_DEPTH, head held, then drains in order
        do_reset();
        lat     = 1;
        stall_d = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (c >= 2) begin
                chk("stall_head_held", {if_valid, if_pc[30:0]}, 32'h8000_0000);
            end
        end
        chk("stall_issued", 32'(issued), 32'd4);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_if_instr", if_instr, mem_word(32'h0));
        stall_d = 1'b0;
        repeat (8) step();
        chk("stall_release_consumed", 32'(consumed), 32'd8);

        // Redirect with a response in the same cycle while decode is stalled
        do_reset();
        lat     = 2;
        stall_d = 1'b1;
        for (int c = 0; c < 10 && !imem_rsp_valid; c++) step();
        chk("redir_rsp_present", 32'(imem_rsp_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("redir_if_valid", 32'(if_valid), 32'd0);
        chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
        chk("redir_req_addr", imem_req_addr, 32'h80);
        stall_d = 1'b0;
        repeat (12) step();
        chk("redir_first_pc", first_pc, 32'h80);

        // Reset mid-burst with two requests outstanding
        do_reset();
        lat = 3;
        repeat (2) step();
        chk("midrst_outstanding", 32'(mem_q.size()), 32'd2);
        rst = 1'b0;
        #1;
        chk("midrst_if_valid", 32'(if_valid), 32'd0);
        chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("midrst_req_addr", imem_req_addr, 32'h0);
        do_reset();
        lat = 1;
        repeat (10) step();
        chk("midrst_restart_consumed", 32'(consumed), 32'd8);
        chk("midrst_restart_first", first_pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
